// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the synchronous instruction memory address, tracks
// the one-cycle read latency, buffers returned words and hands them to decode
// over a valid/ready handshake. Redirects flush all speculative work; halt
// only pauses issue; an out-of-range fetch parks the sequencer in FAULT.
module fetch_sequencer #(
    parameter int RESET_PC   = 0,
    parameter int PC_STEP    = 1,
    parameter int IMEM_WORDS = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0]      PC_LIMIT = 32'(IMEM_WORDS);
    localparam logic [31:0]      PC_INC   = 32'(PC_STEP);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic [31:0]      buf_pc    [BUF_DEPTH];
    logic [31:0]      buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             pop;
    logic             push;
    logic             in_range;
    logic             has_room;
    logic             issue;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

    // Issue decision: room is judged after this cycle's pop and the word already in flight.
    always_comb begin
        pop       = out_valid & out_ready;
        push      = vld_p1 & ~redirect_valid;
        in_range  = (fetch_pc < PC_LIMIT);
        occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
        has_room  = (occupancy < {1'b0, DEPTH_C});
        issue     = (state == S_RUN) & ~halt & ~redirect_valid & in_range & has_room;
    end

    // Control: FSM, fetch pointer, in-flight flag and buffer occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_RUN;
            fetch_pc    <= 32'(RESET_PC);
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            state       <= S_RUN;
            fetch_pc    <= redirect_pc;
            vld_p1      <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_fault <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue)
                fetch_pc <= fetch_pc + PC_INC;
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            case (state)
                S_RUN: begin
                    if (halt)
                        state <= S_HALT;
                    else if (!in_range && has_room) begin
                        state       <= S_FAULT;
                        fetch_fault <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (!halt)
                        state <= S_RUN;
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_RUN;
            endcase
        end
    end

    // Stage p0 -> p1: remember which address the returning word belongs to.
    always_ff @(posedge clock) begin
        if (issue)
            pc_p1 <= fetch_pc;
    end

    // Stage p1 -> buffer: capture the returned word at the tail.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_pc[wr_ptr]    <= pc_p1;
            buf_instr[wr_ptr] <= imem_rdata;
        end
    end

    // Overflow guard: the issue rule must never allow a push into a full buffer.
    always_ff @(posedge clock) begin
        if (!reset)
            assert (!(push && !pop && (count == DEPTH_C)));
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a queue-based reference model
// compared every cycle, plus hand-computed literal checks along the way.
module tb_fetch_sequencer;

    localparam int RESET_PC   = 0;
    localparam int PC_STEP    = 1;
    localparam int IMEM_WORDS = 32;
    localparam int BUF_DEPTH  = 2;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(
        .RESET_PC(RESET_PC), .PC_STEP(PC_STEP),
        .IMEM_WORDS(IMEM_WORDS), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .fetch_fault(fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + pc;
    endfunction

    // Synchronous instruction memory: data for the sampled address one cycle later.
    always @(posedge clock) imem_rdata <= word_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue of pcs, in-flight pc, mode.
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_ipc;
    logic [31:0] m_fpc;
    int          m_mode;   // 0 running, 1 halted, 2 faulted
    bit          m_fault;
    bit          model_ok = 0;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                mq.delete();
                m_infl   = 0;
                m_fpc    = 32'(RESET_PC);
                m_mode   = 0;
                m_fault  = 0;
                model_ok = 1;
            end else if (model_ok) begin
                bit pop, room, iss;
                pop  = (mq.size() > 0) && out_ready;
                room = (mq.size() + int'(m_infl) - int'(pop)) < BUF_DEPTH;
                iss  = (m_mode == 0) && !halt && !redirect_valid
                       && (m_fpc < 32'(IMEM_WORDS)) && room;
                if (redirect_valid) begin
                    mq.delete();
                    m_infl  = 0;
                    m_fpc   = redirect_pc;
                    m_mode  = 0;
                    m_fault = 0;
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (m_infl) mq.push_back(m_ipc);
                    if (m_mode == 0) begin
                        if (halt) m_mode = 1;
                        else if (m_fpc >= 32'(IMEM_WORDS) && room) begin
                            m_mode  = 2;
                            m_fault = 1;
                        end
                    end else if (m_mode == 1 && !halt) begin
                        m_mode = 0;
                    end
                    m_infl = iss;
                    if (iss) begin
                        m_ipc = m_fpc;
                        m_fpc = m_fpc + 32'(PC_STEP);
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_ok) begin
                chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
                chk("m_addr", imem_addr, m_fpc);
                chk("m_fault", 32'(fetch_fault), 32'(m_fault));
                if (mq.size() != 0) begin
                    chk("m_pc", out_pc, mq[0]);
                    chk("m_instr", out_instr, word_at(mq[0]));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1; halt = 0; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc", out_pc, 32'd0);

        // Start-up latency and streaming
        reset = 0;
        tick(); chk("lat_c1_valid", 32'(out_valid), 32'd0);
        tick(); chk("lat_c2_valid", 32'(out_valid), 32'd1);
        chk("lat_c2_pc", out_pc, 32'd0);
        chk("lat_c2_instr", out_instr, 32'h1000_0000);
        tick(); chk("stream_pc1", out_pc, 32'd1);
        tick(); chk("stream_pc2", out_pc, 32'd2);
        tick(); chk("stream_pc3", out_pc, 32'd3);

        // Back-pressure for 5 cycles
        out_ready = 0;
        repeat (5) tick();
        chk("stall_pc", out_pc, 32'd3);
        chk("stall_addr", imem_addr, 32'd5);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1;
        tick(); chk("resume_pc4", out_pc, 32'd4);
        tick(); chk("resume_pc5", out_pc, 32'd5);
        chk("resume_instr5", out_instr, 32'h1000_0005);

        // Redirect while 5 is buffered and 6 is in flight
        redirect_valid = 1; redirect_pc = 32'd20; out_ready = 0;
        tick();
        redirect_valid = 0; out_ready = 1;
        chk("redir_c1_valid", 32'(out_valid), 32'd0);
        chk("redir_c1_addr", imem_addr, 32'd20);
        tick(); chk("redir_c2_valid", 32'(out_valid), 32'd0);
        tick(); chk("redir_pc20", out_pc, 32'd20);
        chk("redir_instr20", out_instr, 32'h1000_0014);
        tick(); chk("redir_pc21", out_pc, 32'd21);

        // Halt for 4 cycles
        halt = 1;
        tick(); chk("halt_inflight_pc", out_pc, 32'd22);
        tick(); chk("halt_drained", 32'(out_valid), 32'd0);
        tick(); tick();
        chk("halt_addr", imem_addr, 32'd23);
        chk("halt_idle", 32'(out_valid), 32'd0);
        halt = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (out_valid) found = 1;
        end
        chk("halt_resume_seen", 32'(found), 32'd1);
        chk("halt_resume_pc", out_pc, 32'd23);

        // Run off the end of memory
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (out_valid && out_pc == 32'd31) found = 1;
        end
        chk("end_pc31_seen", 32'(found), 32'd1);
        chk("end_instr31", out_instr, 32'h1000_001f);
        repeat (3) tick();
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_no_valid", 32'(out_valid), 32'd0);
        chk("fault_addr", imem_addr, 32'd32);

        // Redirect out of FAULT
        redirect_valid = 1; redirect_pc = 32'd0;
        tick();
        redirect_valid = 0;
        chk("fault_cleared", 32'(fetch_fault), 32'd0);
        chk("fault_redir_addr", imem_addr, 32'd0);
        tick(); chk("fault_redir_c2", 32'(out_valid), 32'd0);
        tick(); chk("fault_redir_pc0", out_pc, 32'd0);
        chk("fault_redir_valid", 32'(out_valid), 32'd1);

        // Reset with a full buffer
        out_ready = 0;
        tick();
        chk("full_pc", out_pc, 32'd0);
        chk("full_addr", imem_addr, 32'd2);
        reset = 1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_fault", 32'(fetch_fault), 32'd0);
        chk("mid_rst_addr", imem_addr, 32'(RESET_PC));
        reset = 0; out_ready = 1;
        tick(); chk("restart_c1", 32'(out_valid), 32'd0);
        tick(); chk("restart_pc0", out_pc, 32'd0);
        chk("restart_valid", 32'(out_valid), 32'd1);
        tick(); chk("restart_pc1", out_pc, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
